// File: rtl/n8_c2_multiplier_seq.sv
// Sequential signed 8x8 -> 16 multiplier (shift-add on magnitudes, sign restored at the end).
// Optional macro N8_C2_MUL_EARLY_EXIT_EN: leave MUL as soon as the remaining multiplier bits are zero.
`timescale 1ns/1ps

module n8_c2_multiplier_seq (
  input  logic        clock,
  input  logic        reset_,
  input  logic        soc,
  input  logic [7:0]  x7_x0,
  input  logic [7:0]  y7_y0,
  output logic        eoc,
  output logic [15:0] p15_p0,
  output logic        ow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIX,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  mq_q, mq_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        eoc_q, eoc_d;
  logic [15:0] p_q, p_d;
  logic        ow_q, ow_d;

  logic [15:0] prod;
  logic        last_iter;

  // Two's complement negator used on the operands; 0x80 maps to 0x80, read as unsigned 128.
  function automatic logic [7:0] magnitude(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    eoc_d     = eoc_q;
    p_d       = p_q;
    ow_d      = ow_q;
    prod      = sgn_q ? (~acc_q + 16'd1) : acc_q;
    last_iter = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (soc) begin
          mcand_d = magnitude(x7_x0);
          mq_d    = magnitude(y7_y0);
          sgn_d   = x7_x0[7] ^ y7_y0[7];
          acc_d   = 16'd0;
          cnt_d   = 3'd0;
          eoc_d   = 1'b0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        if (mq_q[0]) begin
          acc_d = acc_q + (16'(mcand_q) << cnt_q);
        end
        mq_d  = mq_q >> 1;
        cnt_d = cnt_q + 3'd1;
`ifdef N8_C2_MUL_EARLY_EXIT_EN
        last_iter = (cnt_q == 3'd7) || (mq_d == 8'd0);
`else
        last_iter = (cnt_q == 3'd7);
`endif
        if (last_iter) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Negating a zero accumulator wraps back to zero, so no special case is needed.
        p_d     = prod;
        ow_d    = (prod[15:8] != {8{prod[7]}});
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!soc) begin
          eoc_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      mcand_q <= 8'd0;
      mq_q    <= 8'd0;
      acc_q   <= 16'd0;
      cnt_q   <= 3'd0;
      sgn_q   <= 1'b0;
      eoc_q   <= 1'b1;
      p_q     <= 16'd0;
      ow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      eoc_q   <= eoc_d;
      p_q     <= p_d;
      ow_q    <= ow_d;
    end
  end

  assign eoc    = eoc_q;
  assign p15_p0 = p_q;
  assign ow     = ow_q;

endmodule

// File: tb/tb_n8_c2_multiplier_seq.sv
// Self-checking bench for n8_c2_multiplier_seq: directed corner cases plus random operands,
// compared against plain signed arithmetic and a latency model of the handshake.
`timescale 1ns/1ps

module tb_n8_c2_multiplier_seq;

  logic        clock;
  logic        reset_;
  logic        soc;
  logic [7:0]  x7_x0;
  logic [7:0]  y7_y0;
  logic        eoc;
  logic [15:0] p15_p0;
  logic        ow;

  int          checks;
  int          failures;
  logic [15:0] prev_p;
  logic        prev_ow;

  n8_c2_multiplier_seq dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .x7_x0  (x7_x0),
    .y7_y0  (y7_y0),
    .eoc    (eoc),
    .p15_p0 (p15_p0),
    .ow     (ow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Number of MUL iterations the reference expects for multiplier y.
  function automatic int mul_iters(input logic [7:0] y);
    int          n;
    logic [7:0]  mag;
    mag = y[7] ? 8'(-int'($signed(y))) : y;
    n   = 1;
    for (int i = 0; i < 8; i++) begin
      if (mag[i]) n = i + 1;
    end
`ifdef N8_C2_MUL_EARLY_EXIT_EN
    return n;
`else
    return (n > 0) ? 8 : 8;
`endif
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge where eoc was seen high.
  // soc is held high for the first `hold` edges (edge 0 .. hold-1).
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y, input int hold);
    int          prod;
    logic [15:0] exp_p;
    logic        exp_ow;
    int          iters;
    int          fix_edge;
    int          rise_exp;
    int          rise;

    prod     = int'($signed(x)) * int'($signed(y));
    exp_p    = prod[15:0];
    exp_ow   = (prod < -128) || (prod > 127);
    iters    = mul_iters(y);
    fix_edge = iters + 1;
    rise_exp = (iters + 2 > hold) ? iters + 2 : hold;

    x7_x0 = x;
    y7_y0 = y;
    soc   = 1'b1;
    @(posedge clock);
    #1;
    x7_x0 = 8'($urandom);
    y7_y0 = 8'($urandom);

    rise = -1;
    for (int e = 0; e < 64 && rise < 0; e++) begin
      @(negedge clock);
      if (e == fix_edge - 1) begin
        check({tag, "_hold_p"}, 32'(p15_p0), 32'(prev_p));
        check({tag, "_hold_ow"}, 32'(ow), 32'(prev_ow));
      end
      if (eoc === 1'b1) begin
        rise = e;
      end else begin
        soc = (e + 1 < hold);
      end
    end
    soc = 1'b0;

    check({tag, "_eoc_edge"}, 32'(rise), 32'(rise_exp));
    check({tag, "_p"}, 32'(p15_p0), 32'(exp_p));
    check({tag, "_ow"}, 32'(ow), 32'(exp_ow));
    prev_p  = exp_p;
    prev_ow = exp_ow;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prev_p   = 16'h0000;
    prev_ow  = 1'b0;
    reset_   = 1'b0;
    soc      = 1'b0;
    x7_x0    = 8'h00;
    y7_y0    = 8'h00;

    repeat (2) @(negedge clock);
    check("reset_eoc", 32'(eoc), 32'd1);
    check("reset_p", 32'(p15_p0), 32'h0000);
    check("reset_ow", 32'(ow), 32'd0);
    reset_ = 1'b1;
    @(negedge clock);

    // Directed corner cases, issued back to back.
    run_op("3x5", 8'h03, 8'h05, 1);
    run_op("m128xm128", 8'h80, 8'h80, 1);
    run_op("127xm128", 8'h7F, 8'h80, 1);
    run_op("m7x6", 8'hF9, 8'h06, 1);
    run_op("m123x0", 8'h85, 8'h00, 1);
    run_op("m1xm1", 8'hFF, 8'hFF, 1);
    run_op("soc_hold15", 8'h12, 8'hF3, 15);

    // Reset in the middle of a -7*6 run.
    x7_x0 = 8'hF9;
    y7_y0 = 8'h06;
    soc   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    soc = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset_ = 1'b0;
    #1;
    check("midrst_eoc", 32'(eoc), 32'd1);
    check("midrst_p", 32'(p15_p0), 32'h0000);
    check("midrst_ow", 32'(ow), 32'd0);
    @(negedge clock);
    reset_  = 1'b1;
    prev_p  = 16'h0000;
    prev_ow = 1'b0;
    @(negedge clock);
    run_op("after_rst_3x5", 8'h03, 8'h05, 1);

    // Random operands, occasionally holding soc longer.
    for (int i = 0; i < 25; i++) begin
      run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
